// File: rtl/gt_seq_cmp_ctrl_if.sv
// rtl/gt_seq_cmp_ctrl_if.sv - requester/result bundle for the sequential magnitude-compare controller
//
// Purpose: groups the start/ready handshake, captured operands and registered
//          compare results of gt_seq_cmp_ctrl into one port.
// Signals:
//   start      requester -> controller  request, sampled only while ready=1
//   a, b       requester -> controller  WIDTH-bit operands, captured on acceptance
//   ready      controller -> requester  high only while idle
//   done_tick  controller -> requester  one-cycle pulse when the flags become valid
//   a_gt_b     controller -> requester  registered A > B
//   a_eq_b     controller -> requester  registered A == B
//   a_lt_b     controller -> requester  registered A < B
//   cycles     controller -> requester  slices examined in the last compare
// Modports: master = requester side, slave = controller side.

interface gt_seq_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = $clog2(NSLICE) + 1;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done_tick;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic [CW-1:0]    cycles;

    modport master (
        output start, a, b,
        input  ready, done_tick, a_gt_b, a_eq_b, a_lt_b, cycles
    );

    modport slave (
        input  start, a, b,
        output ready, done_tick, a_gt_b, a_eq_b, a_lt_b, cycles
    );
endinterface

// File: rtl/gt_seq_cmp_ctrl.sv
// rtl/gt_seq_cmp_ctrl.sv - sequential MSB-first magnitude compare using one 2-bit slice pair
//
// Purpose: captures two WIDTH-bit operands on an accepted start, then walks
//          their 2-bit slices from the most significant one down, using a
//          single pair of 2-bit greater-than slices (A>B and B>A). The first
//          unequal slice decides the result; if all slices match the operands
//          are equal. Result flags are registered and held until the next
//          accepted start.
// Ports:
//   clk    input  rising-edge system clock
//   reset  input  asynchronous, active-high reset
//   bus    slave modport of gt_seq_cmp_ctrl_if (start/a/b in;
//          ready/done_tick/a_gt_b/a_eq_b/a_lt_b/cycles out)

module gt_seq_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    gt_seq_cmp_ctrl_if.slave    bus
);
    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = $clog2(NSLICE) + 1;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic [CW-1:0]    cyc_q, cyc_d;

    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             gt_s;
    logic             lt_s;

    // 2-bit greater-than slice: x > y.
    function automatic logic gt2(input logic [1:0] x, input logic [1:0] y);
        return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
    endfunction

    // The same slice pair is reused every RUN cycle; the index selects
    // which 2-bit window of the captured operands it sees.
    always_comb begin
        slice_a = a_q[{idx_q, 1'b0} +: 2];
        slice_b = b_q[{idx_q, 1'b0} +: 2];
        gt_s    = gt2(slice_a, slice_b);
        lt_s    = gt2(slice_b, slice_a);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= IDX_TOP;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        cyc_d   = cyc_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = IDX_TOP;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    cyc_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                cyc_d = cyc_q + CW'(1);
                if (gt_s) begin
                    gt_d    = 1'b1;
                    state_d = DONE;
                end else if (lt_s) begin
                    lt_d    = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    // Every slice matched down to the LSB slice.
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = (state_q == DONE);
    assign bus.a_gt_b    = gt_q;
    assign bus.a_eq_b    = eq_q;
    assign bus.a_lt_b    = lt_q;
    assign bus.cycles    = cyc_q;

endmodule

// File: tb/tb_gt_seq_cmp_ctrl.sv
// tb/tb_gt_seq_cmp_ctrl.sv - self-checking bench for gt_seq_cmp_ctrl with a reference compare model

module tb_gt_seq_cmp_ctrl;
    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;
    localparam int CW     = $clog2(NSLICE) + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    gt_seq_cmp_ctrl_if #(.WIDTH(WIDTH)) bus ();

    gt_seq_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] flags();
        return {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b};
    endfunction

    // Slices examined = slices from the MSB down to the one holding the
    // highest differing bit; all of them when the operands are equal.
    function automatic int exp_k(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] x;
        int hi;
        x  = av ^ bv;
        hi = -1;
        for (int i = 0; i < WIDTH; i++) if (x[i]) hi = i;
        if (hi < 0) return NSLICE;
        return NSLICE - hi / 2;
    endfunction

    function automatic logic [2:0] exp_flags(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        return {av > bv, av == bv, av < bv};
    endfunction

    // mode 0: operands stable; 1: a forced to all-ones while busy; 2: random operand churn.
    // noise: random start pulses while busy, which must be ignored.
    task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input int mode, input bit noise);
        int  k;
        int  kexp;
        bit  seen;
        kexp = exp_k(av, bv);
        check("ready_idle", bus.ready, 1);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_ready", bus.ready, 0);
        check("flags_cleared", flags(), 0);
        check("cycles_cleared", bus.cycles, 0);
        seen = 1'b0;
        k    = 0;
        for (int n = 1; n <= NSLICE + 2 && !seen; n++) begin
            if (mode == 1) bus.a = '1;
            if (mode == 2) begin
                bus.a = WIDTH'($urandom);
                bus.b = WIDTH'($urandom);
            end
            if (noise) bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (bus.done_tick) begin
                seen = 1'b1;
                k    = n;
            end
        end
        bus.start = 1'b0;
        check("done_seen", seen, 1);
        if (seen) begin
            check("latency", k, kexp);
            check("flags", flags(), exp_flags(av, bv));
            check("cycles", bus.cycles, kexp);
            check("ready_in_done", bus.ready, 0);
            @(posedge clk); #1;
            check("ready_back", bus.ready, 1);
            check("done_one_cycle", bus.done_tick, 0);
            check("flags_hold", flags(), exp_flags(av, bv));
        end
    endtask

    initial begin
        int done_edges[$];
        int dn;
        logic [WIDTH-1:0] ra, rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        #12;
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done_tick, 0);
        check("rst_flags", flags(), 0);
        check("rst_cycles", bus.cycles, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_cmp(8'hC5, 8'h35, 0, 0);
        run_cmp(8'h12, 8'h13, 0, 0);
        run_cmp(8'hA7, 8'hA7, 0, 0);
        run_cmp(8'h2D, 8'h3D, 1, 0);

        // Back-to-back: start held high, acceptance on every ready cycle.
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h7F;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (bus.done_tick) begin
                done_edges.push_back(n);
                check("b2b_flags", flags(), 3'b100);
                check("b2b_cycles", bus.cycles, 1);
            end
        end
        bus.start = 1'b0;
        check("b2b_count", done_edges.size(), 4);
        for (int i = 1; i < done_edges.size(); i++)
            check("b2b_period", done_edges[i] - done_edges[i-1], 3);
        @(posedge clk); #1;
        check("b2b_idle", bus.ready, 1);

        // Asynchronous reset in the second RUN cycle aborts the compare.
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("abort_ready", bus.ready, 1);
        check("abort_done", bus.done_tick, 0);
        check("abort_flags", flags(), 0);
        check("abort_cycles", bus.cycles, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        dn = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (bus.done_tick) dn++;
        end
        check("abort_no_done", dn, 0);
        run_cmp(8'h01, 8'h02, 0, 0);

        // Randomized transactions; b is often a near-copy of a so late
        // slices and equality get exercised.
        for (int t = 0; t < 60; t++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            run_cmp(ra, rb, ($urandom_range(0, 1) == 1) ? 2 : 0, 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
